// File: rtl/aer_readout_ctrl.sv
// AER readout controller: round-robin row grant, round-robin column pick, event out, latch clear.
// Optional event timestamping is enabled with `define AER_TIMESTAMP_EN.
module aer_readout_ctrl #(
  parameter int NROWS   = 16,
  parameter int NCOLS   = 16,
  parameter int SETTLE  = 2,
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 64,
  parameter int TS_W    = 16,
  localparam int RW     = (NROWS > 1) ? $clog2(NROWS) : 1,
  localparam int CW     = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NROWS-1:0] reqy,
  input  logic [NCOLS-1:0] reqx,
  output logic [NROWS-1:0] acky,
  output logic [NCOLS-1:0] ackx_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [RW-1:0]    evt_row,
  output logic [CW-1:0]    evt_col,
`ifdef AER_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_ts,
`endif
  output logic             busy,
  output logic             err_timeout,
  output logic [2:0]       dbg_state
);

  // evt_valid/evt_ready: an event transfers on a rising clk edge where both are high. Once
  // evt_valid rises, evt_row/evt_col/evt_ts hold steady and evt_valid stays high until that
  // transfer; evt_ready while evt_valid is low is ignored.

  localparam int CNT_W = $clog2(TIMEOUT + 16);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_COL_SEL  = 3'd2,
    S_OUT      = 3'd3,
    S_ACK      = 3'd4,
    S_WAIT_CLR = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [NROWS-1:0] reqy_m, reqy_s;
  logic [NCOLS-1:0] reqx_m, reqx_s;
  logic [RW-1:0]    row_ptr, row_ptr_d, row_pick;
  logic [CW-1:0]    col_ptr, col_ptr_d, col_pick;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [NCOLS-1:0] col_mask, mask_d, col_cand;
  logic             row_hit, col_hit;
  logic [NROWS-1:0] acky_d;
  logic [NCOLS-1:0] ackx_d;
  logic             valid_d, err_d;
  logic [RW-1:0]    row_d;
  logic [CW-1:0]    col_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqy_m <= '0;
      reqy_s <= '0;
      reqx_m <= '0;
      reqx_s <= '0;
    end else begin
      reqy_m <= reqy;
      reqy_s <= reqy_m;
      reqx_m <= reqx;
      reqx_s <= reqx_m;
    end
  end

  // Scan downward so the last hit written is the one nearest after the pointer.
  always_comb begin
    int ri;
    ri       = 0;
    row_hit  = 1'b0;
    row_pick = '0;
    for (int i = NROWS; i >= 1; i--) begin
      ri = (int'(row_ptr) + i) % NROWS;
      if (reqy_s[ri]) begin
        row_hit  = 1'b1;
        row_pick = RW'(ri);
      end
    end
  end

  assign col_cand = reqx_s & ~col_mask;

  always_comb begin
    int ci;
    ci       = 0;
    col_hit  = 1'b0;
    col_pick = '0;
    for (int i = NCOLS; i >= 1; i--) begin
      ci = (int'(col_ptr) + i) % NCOLS;
      if (col_cand[ci]) begin
        col_hit  = 1'b1;
        col_pick = CW'(ci);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (row_hit) state_nx = S_SETTLE;
      S_SETTLE:   if (cnt == '0) state_nx = S_COL_SEL;
      S_COL_SEL:  state_nx = col_hit ? S_OUT : S_IDLE;
      S_OUT:      if (evt_valid && evt_ready) state_nx = S_ACK;
      S_ACK:      if (cnt == '0) state_nx = S_WAIT_CLR;
      S_WAIT_CLR: if (!reqx_s[evt_col] || cnt == '0) state_nx = S_COL_SEL;
      default:    state_nx = S_IDLE;
    endcase
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt, ts_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_W'(1);
  end
`endif

  always_comb begin
    acky_d    = acky;
    ackx_d    = ackx_pulse;
    valid_d   = evt_valid;
    row_d     = evt_row;
    col_d     = evt_col;
    err_d     = 1'b0;
    cnt_d     = cnt;
    row_ptr_d = row_ptr;
    col_ptr_d = col_ptr;
    mask_d    = col_mask;
`ifdef AER_TIMESTAMP_EN
    ts_d      = evt_ts;
`endif
    case (state)
      S_IDLE: begin
        if (row_hit) begin
          acky_d           = '0;
          acky_d[row_pick] = 1'b1;
          row_ptr_d        = row_pick;
          cnt_d            = SETTLE_LD;
          mask_d           = '0;
        end
      end
      S_SETTLE: begin
        if (cnt != '0) cnt_d = cnt - CNT_W'(1);
      end
      S_COL_SEL: begin
        if (col_hit) begin
          valid_d   = 1'b1;
          row_d     = row_ptr;
          col_d     = col_pick;
          col_ptr_d = col_pick;
`ifdef AER_TIMESTAMP_EN
          ts_d      = ts_cnt;
`endif
        end else begin
          acky_d = '0;
        end
      end
      S_OUT: begin
        if (evt_valid && evt_ready) begin
          valid_d         = 1'b0;
          ackx_d          = '0;
          ackx_d[evt_col] = 1'b1;
          cnt_d           = PULSE_LD;
        end
      end
      S_ACK: begin
        if (cnt == '0) begin
          ackx_d = '0;
          cnt_d  = TIMEOUT_LD;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_WAIT_CLR: begin
        // A column that never clears is skipped for the rest of this row grant.
        if (reqx_s[evt_col]) begin
          if (cnt == '0) begin
            err_d           = 1'b1;
            mask_d[evt_col] = 1'b1;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acky        <= '0;
      ackx_pulse  <= '0;
      evt_valid   <= 1'b0;
      evt_row     <= '0;
      evt_col     <= '0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      row_ptr     <= '0;
      col_ptr     <= '0;
      col_mask    <= '0;
`ifdef AER_TIMESTAMP_EN
      evt_ts      <= '0;
`endif
    end else begin
      acky        <= acky_d;
      ackx_pulse  <= ackx_d;
      evt_valid   <= valid_d;
      evt_row     <= row_d;
      evt_col     <= col_d;
      err_timeout <= err_d;
      cnt         <= cnt_d;
      row_ptr     <= row_ptr_d;
      col_ptr     <= col_ptr_d;
      col_mask    <= mask_d;
`ifdef AER_TIMESTAMP_EN
      evt_ts      <= ts_d;
`endif
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
